// File: rtl/uart_tx_pkg.sv
// Shared UART transmit types and constants. Optional even parity is built in when
// UART_TX_PARITY_EN is defined; it must match the receiver build.
package uart_tx_pkg;

  localparam int DW          = 8;
  localparam int CounterFull = 434;
  localparam int IdxW        = $clog2(DW);

  typedef logic [2:0] MaxState_t;

  typedef enum MaxState_t {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Parallel-in/serial-out holding register; the parity bit only exists in parity builds.
  typedef struct packed {
    logic [DW-1:0] shreg;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif
  } piso_t;

  function automatic logic even_par(input logic [DW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-side request and serial-side status bundle for uart_tx.
interface uart_tx_if;
  import uart_tx_pkg::*;

  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  modport master (output tx_start, output tx_data, input tx, input tx_busy, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx, output tx_busy, output tx_done);

endinterface

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period counter: runs 0..BIT_CYCLES-1 while not cleared and flags the last cycle
// of each bit period with a one-cycle tick.
module uart_tx_baud_cnt
  import uart_tx_pkg::*;
#(
  parameter int BIT_CYCLES = CounterFull
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last   = (cnt_q == CW'(BIT_CYCLES - 1));
  assign tick_o = !clr_i && last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (last) cnt_d = '0;
    else           cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, LSB-first data, optional even parity
// (UART_TX_PARITY_EN), stop bit. All outputs are registered.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int BIT_CYCLES = CounterFull
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  tx_state_t        state_q, state_d;
  piso_t            piso_q, piso_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  // Counter is held at zero while idle so a new frame always gets a full start bit.
  uart_tx_baud_cnt #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == TX_IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    piso_d  = piso_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (bus.tx_start) begin
          piso_d.shreg = bus.tx_data;
`ifdef UART_TX_PARITY_EN
          piso_d.par   = even_par(bus.tx_data);
`endif
          state_d      = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          idx_d   = '0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tick) begin
          piso_d.shreg = piso_q.shreg >> 1;
          idx_d        = idx_q + 1'b1;
          if (idx_q == IdxW'(DW - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end
        end
      end
      TX_PARITY: begin
        if (tick) state_d = TX_STOP;
      end
      TX_STOP: begin
        if (tick) begin
          state_d = TX_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    busy_d = (state_d != TX_IDLE);
    tx_d   = 1'b1;
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = piso_d.shreg[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_d = piso_d.par;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TX_IDLE;
      piso_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      piso_q  <= piso_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame-level model checked every cycle, plus literal
// bit-centre, length, back-to-back, busy-rejection, reset and loopback checks.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int BC = CounterFull;
`ifdef UART_TX_PARITY_EN
  localparam int NB    = DW + 3;
  localparam bit PAR   = 1'b1;
  localparam int F_LIT = 4774;
`else
  localparam int NB    = DW + 2;
  localparam bit PAR   = 1'b0;
  localparam int F_LIT = 4340;
`endif
  localparam int F = NB * BC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  uart_tx_if bus();

  uart_tx dut (.clk(clk), .rst(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // Frame model: which edge the frame started on and which byte it carries.
  bit            m_active = 1'b0;
  int            m_e0     = 0;
  int            m_done_n = -1;
  logic [DW-1:0] m_byte   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_done_n <= -1;
    end else if (m_active && (ecnt + 1 == m_e0 + F)) begin
      m_active <= 1'b0;
      m_done_n <= ecnt + 1;
    end else if (!m_active && bus.tx_start) begin
      m_active <= 1'b1;
      m_e0     <= ecnt + 1;
      m_byte   <= bus.tx_data;
    end
  end

  function automatic logic exp_tx();
    int bp;
    if (!m_active) return 1'b1;
    bp = (ecnt - m_e0) / BC;
    if (bp == 0)                 return 1'b0;
    if (bp <= DW)                return m_byte[bp-1];
    if (PAR && bp == DW + 1)     return ^m_byte;
    return 1'b1;
  endfunction

  int vec = 0;
  int err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic wait_to(input int t);
    while (ecnt < t) @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] b, output int e0);
    @(negedge clk);
    bus.tx_start = 1'b1;
    bus.tx_data  = b;
    @(negedge clk);
    e0 = ecnt;
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_done(input int e0, output int dn);
    int lim;
    lim = e0 + F + 20;
    while (!bus.tx_done && ecnt < lim) @(negedge clk);
    if (!bus.tx_done) begin
      vec++;
      err++;
      $display("FAIL done_timeout: no tx_done within %0d edges of %0d", F + 20, e0);
    end
    dn = ecnt;
  endtask

  // Receiver stand-in: samples each bit at its centre.
  task automatic rx(input int e0, output logic [DW-1:0] d, output logic perr, output logic stop);
    logic b;
    d = '0; perr = 1'b0; stop = 1'b0;
    for (int k = 0; k < NB; k++) begin
      wait_to(e0 + k * BC + BC / 2);
      b = bus.tx;
      if (k >= 1 && k <= DW)          d[k-1] = b;
      else if (PAR && k == DW + 1)    perr = b ^ (^d);
      else if (k == NB - 1)           stop = b;
    end
  endtask

  int e0, e1, dn;
  int exp55[$];
  logic [DW-1:0] got;
  logic perr, stop;
  logic [DW-1:0] lb [3];

  initial begin
    bus.tx_start = 1'b0;
    bus.tx_data  = '0;
`ifdef UART_TX_PARITY_EN
    exp55 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
`else
    exp55 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h3C;

    fork
      forever begin
        @(negedge clk);
        chk($sformatf("cycle%0d", ecnt), {29'd0, bus.tx, bus.tx_busy, bus.tx_done},
            {29'd0, exp_tx(), m_active, (!m_active && m_done_n == ecnt)});
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.tx_busy, 0);
    chk("rst_done", bus.tx_done, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 0x55 single frame, bit-centre pattern and length
    send(8'h55, e0);
    for (int k = 0; k < NB; k++) begin
      wait_to(e0 + k * BC + BC / 2);
      chk($sformatf("bit55_%0d", k), bus.tx, exp55[k]);
    end
    wait_done(e0, dn);
    chk("len55", dn - e0, F_LIT);
    chk("busy_at_done55", bus.tx_busy, 0);
    @(negedge clk);
    chk("done_one_cycle", bus.tx_done, 0);

    // 0x07 / 0xA3: parity bit (or stop bit in the plain build) at slot DW+1
    send(8'h07, e0);
    wait_to(e0 + (DW + 1) * BC + BC / 2);
    chk("slot9_07", bus.tx, 1);
    wait_done(e0, dn);
    chk("len07", dn - e0, F_LIT);
    send(8'hA3, e0);
    wait_to(e0 + (DW + 1) * BC + BC / 2);
    chk("slot9_A3", bus.tx, PAR ? 0 : 1);
    wait_done(e0, dn);
    chk("lenA3", dn - e0, F_LIT);

    // back-to-back: start strobe in the tx_done cycle
    send(8'h81, e0);
    wait_to(e0 + F - BC);
    chk("stop_first", bus.tx, 1);
    wait_to(e0 + F - 1);
    chk("stop_last", bus.tx, 1);
    wait_done(e0, dn);
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'hF0;
    @(negedge clk);
    e1 = ecnt;
    bus.tx_start = 1'b0;
    chk("b2b_start_tx", bus.tx, 0);
    chk("b2b_busy", bus.tx_busy, 1);
    chk("b2b_gap", e1 - e0, F_LIT + 1);
    rx(e1, got, perr, stop);
    chk("b2b_byte", got, 8'hF0);
    wait_done(e1, dn);

    // busy rejection: second request mid-frame must vanish
    send(8'h12, e0);
    wait_to(e0 + 1000);
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'hFF;
    @(negedge clk);
    bus.tx_start = 1'b0;
    wait_done(e0, dn);
    chk("len12", dn - e0, F_LIT);
    wait_to(dn + 300);
    chk("no_requeue", bus.tx_busy, 0);

    // reset mid-frame
    send(8'h00, e0);
    wait_to(e0 + 1000);
    chk("pre_rst_tx", bus.tx, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", bus.tx, 1);
    chk("mid_rst_busy", bus.tx_busy, 0);
    chk("mid_rst_done", bus.tx_done, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    chk("post_rst_idle", bus.tx_busy, 0);

    // loopback through the bench receiver
    for (int i = 0; i < 3; i++) begin
      send(lb[i], e0);
      rx(e0, got, perr, stop);
      chk($sformatf("loop_byte%0d", i), got, lb[i]);
      chk($sformatf("loop_perr%0d", i), perr, 0);
      chk($sformatf("loop_stop%0d", i), stop, 1);
      wait_done(e0, dn);
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
